// File: rtl/dram_cmd_sequencer.sv
// DRAM command sequencer: turns one decoded request at a time into a
// PRE/ACT/READ/WRITE sequence under an open-page policy, tracking the open
// row and ACT age of all 16 banks, and pulses done when the burst completes.
module dram_cmd_sequencer #(
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RAS   = 52,
    parameter int T_CL    = 24,
    parameter int T_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    output logic        cmd_valid,
    output logic [1:0]  cmd,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [13:0] cmd_row,
    output logic [10:0] cmd_col,
    output logic        done,
    output logic [1:0]  done_op
);
    localparam logic [1:0] CMD_PRE = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_RD  = 2'd2;
    localparam logic [1:0] CMD_ACT = 2'd3;

    // Wait-counter reload values. The ISSUE state and the cycle that leaves
    // the WAIT state both count, hence the -2 on the command-to-command gaps.
    localparam logic [7:0] RP_LD   = 8'(T_RP - 2);
    localparam logic [7:0] RCD_LD  = 8'(T_RCD - 2);
    localparam logic [7:0] RW_LD   = 8'(T_CL + T_BURST - 1);
    // Age reads 0 the cycle after ACT and PRE goes out the cycle after the
    // check, so PRE is legal next cycle once age >= T_RAS-2.
    localparam logic [7:0] RAS_THR = 8'(T_RAS - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_PRE_WAIT_RAS, S_PRE_ISSUE, S_PRE_WAIT,
        S_ACT_ISSUE, S_ACT_WAIT, S_RW_ISSUE, S_RW_WAIT
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [1:0]         r_bg;
    logic [1:0]         r_ba;
    logic [13:0]        r_row;
    logic [10:0]        r_col;
    logic [7:0]         r_wait;
    logic [15:0]        r_open;
    logic [15:0][13:0]  r_open_row;
    logic [15:0][7:0]   r_age;

    logic               r_cmd_valid;
    logic [1:0]         r_cmd;
    logic [1:0]         r_cmd_bg;
    logic [1:0]         r_cmd_ba;
    logic [13:0]        r_cmd_row;
    logic [10:0]        r_cmd_col;
    logic               r_done;
    logic [1:0]         r_done_op;

    logic [3:0]         w_bank;
    logic               w_hit;
    logic               w_ras_ok;
    logic [1:0]         w_rw_cmd;
    logic               w_unused_addr;

    assign w_bank        = {r_bg, r_ba};
    assign w_hit         = r_open[w_bank] && (r_open_row[w_bank] == r_row);
    assign w_ras_ok      = (r_age[w_bank] >= RAS_THR);
    assign w_rw_cmd      = (r_op == 2'd1) ? CMD_WR : CMD_RD;
    assign w_unused_addr = ^req_addr[2:0];

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd;
    assign cmd_bg    = r_cmd_bg;
    assign cmd_ba    = r_cmd_ba;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign done      = r_done;
    assign done_op   = r_done_op;

    // Bank table: open flag / open row per bank, plus saturating ACT age.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open     <= '0;
            r_open_row <= '0;
            r_age      <= {16{8'hFF}};
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (r_state == S_ACT_ISSUE && w_bank == b[3:0])
                    r_age[b] <= 8'd0;
                else if (r_age[b] != 8'hFF)
                    r_age[b] <= r_age[b] + 8'd1;
            end
            if (r_state == S_PRE_ISSUE)
                r_open[w_bank] <= 1'b0;
            if (r_state == S_ACT_ISSUE) begin
                r_open[w_bank]     <= 1'b1;
                r_open_row[w_bank] <= r_row;
            end
        end
    end

    // Sequencer FSM; command fields are registered on entry to each ISSUE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_bg        <= '0;
            r_ba        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_wait      <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_cmd_bg    <= '0;
            r_cmd_ba    <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_done      <= 1'b0;
            r_done_op   <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_op    <= req_op;
                    r_bg    <= req_addr[7:6];
                    r_ba    <= req_addr[9:8];
                    r_col   <= {req_addr[17:10], req_addr[5:3]};
                    r_row   <= req_addr[31:18];
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_cmd_bg <= r_bg;
                    r_cmd_ba <= r_ba;
                    if (w_hit) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= w_rw_cmd;
                        r_cmd_col   <= r_col;
                        r_state     <= S_RW_ISSUE;
                    end else if (!r_open[w_bank]) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_ACT;
                        r_cmd_row   <= r_row;
                        r_state     <= S_ACT_ISSUE;
                    end else if (w_ras_ok) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_PRE;
                        r_state     <= S_PRE_ISSUE;
                    end else begin
                        r_state     <= S_PRE_WAIT_RAS;
                    end
                end
                S_PRE_WAIT_RAS: if (w_ras_ok) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd       <= CMD_PRE;
                    r_state     <= S_PRE_ISSUE;
                end
                S_PRE_ISSUE: begin
                    r_wait  <= RP_LD;
                    r_state <= S_PRE_WAIT;
                end
                S_PRE_WAIT: begin
                    if (r_wait == 8'd0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_ACT;
                        r_cmd_row   <= r_row;
                        r_state     <= S_ACT_ISSUE;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                S_ACT_ISSUE: begin
                    r_wait  <= RCD_LD;
                    r_state <= S_ACT_WAIT;
                end
                S_ACT_WAIT: begin
                    if (r_wait == 8'd0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= w_rw_cmd;
                        r_cmd_col   <= r_col;
                        r_state     <= S_RW_ISSUE;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                S_RW_ISSUE: begin
                    r_wait  <= RW_LD;
                    r_state <= S_RW_WAIT;
                end
                S_RW_WAIT: begin
                    // done is high during the last RW_WAIT cycle; IDLE follows.
                    if (r_wait == 8'd1) begin
                        r_done    <= 1'b1;
                        r_done_op <= r_op;
                    end
                    if (r_wait == 8'd0)
                        r_state <= S_IDLE;
                    else
                        r_wait <= r_wait - 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: default-timing instance for the main
// flows plus a long-tRAS instance so the PRE hold on tRAS is exercised.
module tb_dram_cmd_sequencer;
    localparam int K_PRE = 0, K_WR = 1, K_RD = 2, K_ACT = 3, K_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic        cmd_valid, done;
    logic [1:0]  cmd, cmd_bg, cmd_ba, done_op;
    logic [13:0] cmd_row;
    logic [10:0] cmd_col;

    logic        req_valid2 = 1'b0, req_ready2;
    logic [1:0]  req_op2 = '0;
    logic [31:0] req_addr2 = '0;
    logic        cmd_valid2, done2;
    logic [1:0]  cmd2, cmd_bg2, cmd_ba2, done_op2;
    logic [13:0] cmd_row2;
    logic [10:0] cmd_col2;

    dram_cmd_sequencer u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .done(done), .done_op(done_op)
    );

    dram_cmd_sequencer #(.T_RAS(80)) u_ras (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op2), .req_addr(req_addr2), .cmd_valid(cmd_valid2), .cmd(cmd2),
        .cmd_bg(cmd_bg2), .cmd_ba(cmd_ba2), .cmd_row(cmd_row2), .cmd_col(cmd_col2),
        .done(done2), .done_op(done_op2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int u; int c; int k; int bg; int ba; int row; int col; int rdy;
    } ev_t;

    ev_t  evq[$];
    bit   saw_done = 1'b0;
    int   n_chk = 0, n_err = 0, consec = 0;
    logic pcv = 1'b0, pcv2 = 1'b0;

    // Event monitor: logs every command and done pulse of both instances.
    always @(negedge clk) begin
        ev_t e;
        if (cmd_valid === 1'b1) begin
            e.u = 0; e.c = cyc; e.k = int'(cmd); e.bg = int'(cmd_bg); e.ba = int'(cmd_ba);
            e.row = int'(cmd_row); e.col = int'(cmd_col); e.rdy = int'(req_ready);
            evq.push_back(e);
        end
        if (done === 1'b1) begin
            e.u = 0; e.c = cyc; e.k = K_DONE; e.bg = 0; e.ba = 0; e.row = 0;
            e.col = int'(done_op); e.rdy = int'(req_ready);
            evq.push_back(e);
            saw_done = 1'b1;
        end
        if (cmd_valid2 === 1'b1) begin
            e.u = 1; e.c = cyc; e.k = int'(cmd2); e.bg = int'(cmd_bg2); e.ba = int'(cmd_ba2);
            e.row = int'(cmd_row2); e.col = int'(cmd_col2); e.rdy = int'(req_ready2);
            evq.push_back(e);
        end
        if (done2 === 1'b1) begin
            e.u = 1; e.c = cyc; e.k = K_DONE; e.bg = 0; e.ba = 0; e.row = 0;
            e.col = int'(done_op2); e.rdy = int'(req_ready2);
            evq.push_back(e);
            saw_done = 1'b1;
        end
        if (cmd_valid === 1'b1 && pcv === 1'b1) consec++;
        if (cmd_valid2 === 1'b1 && pcv2 === 1'b1) consec++;
        pcv  = cmd_valid;
        pcv2 = cmd_valid2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int u, input logic [1:0] op, input logic [31:0] a, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        saw_done = 1'b0;
        @(posedge clk); #1;
        if (u == 0) begin req_valid = 1'b1; req_op = op; req_addr = a; end
        else begin req_valid2 = 1'b1; req_op2 = op; req_addr2 = a; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((u == 0 && req_ready === 1'b1) || (u == 1 && req_ready2 === 1'b1)) begin
                acc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        req_valid2 = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic run_req(input int u, input logic [1:0] op, input logic [31:0] a, output int acc);
        bit ok;
        ok = 1'b0;
        send(u, op, a, acc);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            ok = saw_done;
        end
        #1;
        chk("done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("ready_after_done", (u == 0) ? 32'(req_ready) : 32'(req_ready2), 32'd1);
    endtask

    task automatic expect_ev(input string tag, input int u, input int k, input int c,
                             input int bg, input int ba, input int row, input int col);
        ev_t e;
        if (evq.size() == 0) begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
            return;
        end
        e = evq.pop_front();
        chk({tag, "_unit"}, e.u, u);
        chk({tag, "_kind"}, e.k, k);
        chk({tag, "_cyc"}, e.c, c);
        if (k != K_DONE) begin
            chk({tag, "_bg"}, e.bg, bg);
            chk({tag, "_ba"}, e.ba, ba);
        end
        if (k == K_ACT) chk({tag, "_row"}, e.row, row);
        if (k == K_RD || k == K_WR) chk({tag, "_col"}, e.col, col);
        if (k == K_DONE) begin
            chk({tag, "_op"}, e.col, col);
            chk({tag, "_rdy_low"}, e.rdy, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_bg_ba", 32'({cmd_bg, cmd_ba}), 32'd0);
        chk("rst_row", 32'(cmd_row), 32'd0);
        chk("rst_col", 32'(cmd_col), 32'd0);
        chk("rst_done", 32'({done, done_op}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        evq.delete();

        // Long-tRAS instance: conflict PRE must wait for ACT+80
        run_req(1, 2'd0, 32'h0004_0000, a1);
        run_req(1, 2'd1, 32'h0008_0000, a2);
        expect_ev("ras_act1", 1, K_ACT, a1 + 2, 0, 0, 1, 0);
        expect_ev("ras_rd", 1, K_RD, a1 + 26, 0, 0, 0, 0);
        expect_ev("ras_done1", 1, K_DONE, a1 + 54, 0, 0, 0, 0);
        expect_ev("ras_pre", 1, K_PRE, a1 + 82, 0, 0, 0, 0);
        expect_ev("ras_act2", 1, K_ACT, a1 + 106, 0, 0, 2, 0);
        expect_ev("ras_wr", 1, K_WR, a1 + 130, 0, 0, 0, 0);
        expect_ev("ras_done2", 1, K_DONE, a1 + 158, 0, 0, 0, 1);
        chk("ras_extra", evq.size(), 0);
        evq.delete();

        // Closed bank read
        run_req(0, 2'd0, 32'h0004_0000, a);
        expect_ev("t1_act", 0, K_ACT, a + 2, 0, 0, 1, 0);
        expect_ev("t1_rd", 0, K_RD, a + 26, 0, 0, 0, 0);
        expect_ev("t1_done", 0, K_DONE, a + 54, 0, 0, 0, 0);
        chk("t1_extra", evq.size(), 0);

        // Row hit, instruction fetch
        run_req(0, 2'd2, 32'h0004_0008, a);
        expect_ev("t2_rd", 0, K_RD, a + 2, 0, 0, 0, 1);
        expect_ev("t2_done", 0, K_DONE, a + 30, 0, 0, 0, 2);
        chk("t2_extra", evq.size(), 0);

        // Row conflict write, tRAS long satisfied
        run_req(0, 2'd1, 32'h0008_0000, a);
        expect_ev("t3_pre", 0, K_PRE, a + 2, 0, 0, 0, 0);
        expect_ev("t3_act", 0, K_ACT, a + 26, 0, 0, 2, 0);
        expect_ev("t3_wr", 0, K_WR, a + 50, 0, 0, 0, 0);
        expect_ev("t3_done", 0, K_DONE, a + 78, 0, 0, 0, 1);
        chk("t3_extra", evq.size(), 0);

        // Address mapping with all fields nonzero, op 3 as READ
        run_req(0, 2'd3, 32'h0016_AFAF, a);
        expect_ev("t4_act", 0, K_ACT, a + 2, 2, 3, 5, 0);
        expect_ev("t4_rd", 0, K_RD, a + 26, 2, 3, 0, 11'h55D);
        expect_ev("t4_done", 0, K_DONE, a + 54, 0, 0, 0, 3);
        chk("t4_extra", evq.size(), 0);

        // Reset during ACT_WAIT of a conflict sequence
        send(0, 2'd0, 32'h0004_0000, a);
        repeat (34) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_release", 32'(req_ready), 32'd1);
        repeat (60) @(posedge clk);
        #1;
        expect_ev("t5_pre", 0, K_PRE, a + 2, 0, 0, 0, 0);
        expect_ev("t5_act", 0, K_ACT, a + 26, 0, 0, 1, 0);
        chk("t5_no_more", evq.size(), 0);
        chk("t5_no_done", 32'(saw_done), 32'd0);
        evq.delete();

        // Same address after reset: bank closed, fresh ACT
        run_req(0, 2'd0, 32'h0004_0000, a);
        expect_ev("t6_act", 0, K_ACT, a + 2, 0, 0, 1, 0);
        expect_ev("t6_rd", 0, K_RD, a + 26, 0, 0, 0, 0);
        expect_ev("t6_done", 0, K_DONE, a + 54, 0, 0, 0, 0);

        // Bank independence: bg1 opens without touching bg0
        run_req(0, 2'd0, 32'h0004_0040, a);
        expect_ev("t7_act", 0, K_ACT, a + 2, 1, 0, 1, 0);
        expect_ev("t7_rd", 0, K_RD, a + 26, 1, 0, 0, 0);
        expect_ev("t7_done", 0, K_DONE, a + 54, 0, 0, 0, 0);

        run_req(0, 2'd2, 32'h0004_0000, a);
        expect_ev("t8_rd", 0, K_RD, a + 2, 0, 0, 0, 0);
        expect_ev("t8_done", 0, K_DONE, a + 30, 0, 0, 0, 2);
        chk("t8_extra", evq.size(), 0);

        chk("no_back_to_back_cmd", consec, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
